// File: rtl/mult_div_if.sv
// Request/result bundle between the multicycle control unit and the
// iterative multiply/divide unit. The control unit is the master.
interface mult_div_if;
  logic        mult_start;
  logic        div_start;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divby0;

  modport master (
    output mult_start, div_start, srca, srcb,
    input  hi, lo, busy, done, divby0
  );

  modport slave (
    input  mult_start, div_start, srca, srcb,
    output hi, lo, busy, done, divby0
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing the MIPS HI/LO pair.
// Multiply uses radix-2 Booth, divide uses restoring division on operand
// magnitudes with a sign fix on the final write. Both take 32 steps.
// Optional feature: define MULTDIV_DIVBY0_TRAP_EN to short-circuit a divide
// by zero into a one-cycle done+divby0 response with HI/LO left unchanged.
//
// state | meaning
// IDLE  | waiting for mult_start / div_start
// MULT  | Booth multiply step per cycle
// DIV   | restoring divide step per cycle
// DONE  | result written, done pulse high for one cycle
module mult_div_unit (
  input logic      clk,
  input logic      reset,
  mult_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  count;
  // acc is one bit wider than the datapath so Booth add/sub never overflows
  logic [32:0] acc;
  logic [31:0] mq;
  logic [31:0] opb;
  logic        q1;
  logic        neg_q, neg_r;
  logic [31:0] res_hi, res_lo;
  logic        done_pulse, dz_flag;

  logic [32:0] booth_sum, shifted;
  logic [33:0] diff;
  logic [32:0] step_acc;
  logic [31:0] step_mq;
  logic        step_q1;
  logic        last_step;
  logic        trap;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

`ifdef MULTDIV_DIVBY0_TRAP_EN
  assign trap = bus.div_start && !bus.mult_start && (bus.srcb == 32'd0);
`else
  assign trap = 1'b0;
`endif

  assign last_step  = (count == 6'd31);
  assign bus.hi     = res_hi;
  assign bus.lo     = res_lo;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_pulse;
  assign bus.divby0 = dz_flag;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; mult has priority over div when both are requested.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.mult_start)     state_next = MULT;
        else if (bus.div_start) state_next = trap ? DONE : DIV;
      end
      MULT, DIV: if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of Booth (MULT) or restoring division (DIV).
  always_comb begin
    booth_sum = acc;
    case ({mq[0], q1})
      2'b01:   booth_sum = acc + {opb[31], opb};
      2'b10:   booth_sum = acc - {opb[31], opb};
      default: booth_sum = acc;
    endcase
    shifted  = {acc[31:0], mq[31]};
    diff     = {1'b0, shifted} - {2'b00, opb};
    step_acc = acc;
    step_mq  = mq;
    step_q1  = q1;
    if (state == MULT) begin
      step_acc = {booth_sum[32], booth_sum[32:1]};
      step_mq  = {booth_sum[0], mq[31:1]};
      step_q1  = mq[0];
    end else if (state == DIV) begin
      if (!diff[33]) begin
        step_acc = diff[32:0];
        step_mq  = {mq[30:0], 1'b1};
      end else begin
        step_acc = shifted;
        step_mq  = {mq[30:0], 1'b0};
      end
    end
  end

  // Operand capture, iteration registers, result write and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 6'd0;
      acc        <= 33'd0;
      mq         <= 32'd0;
      opb        <= 32'd0;
      q1         <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      res_hi     <= 32'd0;
      res_lo     <= 32'd0;
      done_pulse <= 1'b0;
      dz_flag    <= 1'b0;
    end else begin
      done_pulse <= (state_next == DONE);
      dz_flag    <= (state == IDLE) && trap;
      case (state)
        IDLE: begin
          if (bus.mult_start) begin
            acc   <= 33'd0;
            mq    <= bus.srcb;
            opb   <= bus.srca;
            q1    <= 1'b0;
            count <= 6'd0;
          end else if (bus.div_start) begin
            acc   <= 33'd0;
            mq    <= mag(bus.srca);
            opb   <= mag(bus.srcb);
            q1    <= 1'b0;
            neg_q <= bus.srca[31] ^ bus.srcb[31];
            neg_r <= bus.srca[31];
            count <= 6'd0;
          end
        end
        MULT: begin
          acc   <= step_acc;
          mq    <= step_mq;
          q1    <= step_q1;
          count <= count + 6'd1;
          if (last_step) begin
            res_hi <= step_acc[31:0];
            res_lo <= step_mq;
          end
        end
        DIV: begin
          acc   <= step_acc;
          mq    <= step_mq;
          count <= count + 6'd1;
          // quotient truncates toward zero, remainder follows the dividend
          if (last_step) begin
            res_lo <= neg_q ? (~step_mq + 32'd1) : step_mq;
            res_hi <= neg_r ? (~step_acc[31:0] + 32'd1) : step_acc[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: each scenario task drives one operation
// and compares results, latency and handshake behaviour against
// hand-computed values.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mult_div_if bus();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one request at a posedge (E0), then observe 40 cycles at negedges.
  // Sample index i corresponds to the cycle following edge Ei.
  // If inj >= 0 a div_start (100/7) is pulsed while the unit is busy.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input int inj,
                        output int lat, output int nbusy, output int ndone,
                        output int ndz, output int ndzd);
    lat = -1; nbusy = 0; ndone = 0; ndz = 0; ndzd = 0;
    @(negedge clk);
    bus.mult_start = m; bus.div_start = d; bus.srca = a; bus.srcb = b;
    @(posedge clk);
    #1;
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (bus.divby0) ndz++;
      if (bus.divby0 && bus.done) ndzd++;
      if (i == inj) begin
        bus.div_start = 1'b1; bus.srca = 32'd100; bus.srcb = 32'd7;
      end else if (i == inj + 1) begin
        bus.div_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.divby0 !== 1'b0) begin failures++; $display("FAIL reset_divby0: got %b want 0", bus.divby0); end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int lat, nb, nd, nz, nzd;
    run_op(1'b1, 1'b0, 32'hFFFFFFFD, 32'd7, -1, lat, nb, nd, nz, nzd);
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_hi: got %h want FFFFFFFF", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_lo: got %h want FFFFFFEB", bus.lo); end
    checks++; if (lat !== 32) begin failures++; $display("FAIL mult_latency: got %0d want 32", lat); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL mult_done_count: got %0d want 1", nd); end
    // busy spans the cycles after E0 through the DONE cycle (E32-E33)
    checks++; if (nb !== 33) begin failures++; $display("FAIL mult_busy_cycles: got %0d want 33", nb); end
    checks++; if (nz !== 0) begin failures++; $display("FAIL mult_divby0: got %0d want 0", nz); end
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'h40000000_00000000) begin failures++; $display("FAIL mult_minmin: got %h%h want 4000000000000000", bus.hi, bus.lo); end
    run_op(1'b1, 1'b0, 32'h12345678, 32'h00000010, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'h00000001_23456780) begin failures++; $display("FAIL mult_pos: got %h%h want 0000000123456780", bus.hi, bus.lo); end
    repeat (5) @(negedge clk);
    checks++; if (bus.lo !== 32'h23456780) begin failures++; $display("FAIL mult_hold_lo: got %h want 23456780", bus.lo); end
  endtask

  task automatic test_div_sign;
    int lat, nb, nd, nz, nzd;
    run_op(1'b0, 1'b1, -32'sd7, 32'd2, -1, lat, nb, nd, nz, nzd);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_m7_2_lo: got %h want FFFFFFFD", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_m7_2_hi: got %h want FFFFFFFF", bus.hi); end
    checks++; if (lat !== 32) begin failures++; $display("FAIL div_latency: got %0d want 32", lat); end
    run_op(1'b0, 1'b1, 32'd7, -32'sd2, -1, lat, nb, nd, nz, nzd);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_7_m2_lo: got %h want FFFFFFFD", bus.lo); end
    checks++; if (bus.hi !== 32'h00000001) begin failures++; $display("FAIL div_7_m2_hi: got %h want 00000001", bus.hi); end
    run_op(1'b0, 1'b1, -32'sd7, -32'sd2, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_00000003) begin failures++; $display("FAIL div_m7_m2: got %h %h want FFFFFFFF 00000003", bus.hi, bus.lo); end
    run_op(1'b0, 1'b1, 32'd100, 32'd7, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'h00000002_0000000E) begin failures++; $display("FAIL div_100_7: got %h %h want 00000002 0000000E", bus.hi, bus.lo); end
  endtask

  task automatic test_overflow_collision;
    int lat, nb, nd, nz, nzd;
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_overflow: got %h %h want 00000000 80000000", bus.hi, bus.lo); end
    checks++; if (nz !== 0) begin failures++; $display("FAIL div_overflow_flag: got %0d want 0", nz); end
    run_op(1'b1, 1'b1, 32'd6, 32'd5, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'h00000000_0000001E) begin failures++; $display("FAIL collision_mult_wins: got %h %h want 00000000 0000001E", bus.hi, bus.lo); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL collision_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_back_to_back;
    int lat, nb, nd, nz, nzd;
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 5, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'h00000000_0000000C) begin failures++; $display("FAIL restart_result: got %h %h want 00000000 0000000C", bus.hi, bus.lo); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL restart_done_count: got %0d want 1", nd); end
    checks++; if (lat !== 32) begin failures++; $display("FAIL restart_latency: got %0d want 32", lat); end
  endtask

  task automatic test_reset_mid;
    int lat, nb, nd, nz, nzd;
    // previous result (12) is nonzero, so the clear is observable
    @(negedge clk);
    bus.mult_start = 1'b1; bus.srca = 32'h11111111; bus.srcb = 32'd3;
    @(posedge clk);
    #1 bus.mult_start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if ({bus.hi, bus.lo} !== 64'd0) begin failures++; $display("FAIL midreset_hilo: got %h %h want 0 0", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    #1 reset = 1'b0;
    run_op(1'b1, 1'b0, 32'hFFFFFFFD, 32'd7, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFEB) begin failures++; $display("FAIL midreset_next_op: got %h %h want FFFFFFFF FFFFFFEB", bus.hi, bus.lo); end
    checks++; if (lat !== 32) begin failures++; $display("FAIL midreset_next_latency: got %0d want 32", lat); end
  endtask

  task automatic test_divby0;
    int lat, nb, nd, nz, nzd;
    run_op(1'b1, 1'b0, 32'd6, 32'd5, -1, lat, nb, nd, nz, nzd);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, lat, nb, nd, nz, nzd);
`ifdef MULTDIV_DIVBY0_TRAP_EN
    checks++; if (lat !== 0) begin failures++; $display("FAIL dz_latency: got %0d want 0", lat); end
    checks++; if (nb !== 1) begin failures++; $display("FAIL dz_busy_cycles: got %0d want 1", nb); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL dz_done_count: got %0d want 1", nd); end
    checks++; if (nz !== 1 || nzd !== 1) begin failures++; $display("FAIL dz_flag: got %0d/%0d want 1/1", nz, nzd); end
    checks++; if ({bus.hi, bus.lo} !== 64'h00000000_0000001E) begin failures++; $display("FAIL dz_hilo_kept: got %h %h want 00000000 0000001E", bus.hi, bus.lo); end
`else
    checks++; if (lat !== 32) begin failures++; $display("FAIL dz_latency: got %0d want 32", lat); end
    checks++; if (nz !== 0) begin failures++; $display("FAIL dz_flag: got %0d want 0", nz); end
    checks++; if ({bus.hi, bus.lo} !== 64'h00000005_FFFFFFFF) begin failures++; $display("FAIL dz_pos_result: got %h %h want 00000005 FFFFFFFF", bus.hi, bus.lo); end
    run_op(1'b0, 1'b1, -32'sd5, 32'd0, -1, lat, nb, nd, nz, nzd);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFB_00000001) begin failures++; $display("FAIL dz_neg_result: got %h %h want FFFFFFFB 00000001", bus.hi, bus.lo); end
`endif
  endtask

  initial begin
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.srca       = 32'd0;
    bus.srcb       = 32'd0;
    test_reset();
    test_mult();
    test_div_sign();
    test_overflow_collision();
    test_back_to_back();
    test_reset_mid();
    test_divby0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
